cmp_share_arb: RTL and testbench
================================

Name: cmp_share_arb

Overview:
- Time-shares one 4-bit magnitude comparator among N_REQ requesters, with round-robin arbitration and a req/gnt/rsp handshake.
- Sits between the lab's switch/counter sources and the shared comparator, 7-segment and LED outputs.
- Returns a per-transaction result tagged with the requester id.
- Holds the last result for display: 4-bit digit for the segment decoder, and last operand pair on the LEDs.

Parameters:
- N_REQ, 4, number of requesters; 2..8.
- W, 4, operand width in bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; level, held until granted.
- a_bus  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
- b_bus  in  N_REQ*W  operand B, same packing as a_bus.
- gnt  out  N_REQ  one-hot, one-cycle grant; operands were captured at the edge that raised it.
- busy  out  1  high while a transaction is in flight (state != IDLE).
- rsp_valid  out  1  one-cycle pulse; rsp_* fields valid only while high.
- rsp_id  out  clog2(N_REQ)  index of the served requester.
- rsp_gt  out  1  1 when A > B.
- rsp_eq  out  1  1 when A == B.
- disp_bin  out  4  last result for the 7-seg decoder: 0 when A <= B, 1 when A > B.
- led  out  2*W  last served operands {A,B}.

Behaviour:
- Reset:
  - State IDLE; round-robin pointer ptr = 0.
  - gnt, rsp_valid, rsp_id, rsp_gt, rsp_eq, busy, disp_bin and led all 0.
  - Operand registers cleared.
- FSM states: IDLE -> GRANT -> RESP -> IDLE.
- IDLE:
  - req is sampled only in this state; with req == 0, stay in IDLE.
  - Winner = first set bit searching upward from ptr, wrapping modulo N_REQ.
  - At the edge: capture winner's A and B into operand registers, set gnt[winner] = 1, latch the winner id, go to GRANT.
- GRANT:
  - gnt is visible this cycle; the requester must drop req at this edge.
  - At the edge: gnt <= 0; register the comparator outputs into rsp_gt/rsp_eq; rsp_id <= winner; rsp_valid <= 1.
  - Also at this edge: disp_bin <= {3'b0, gt}; led <= {A,B}; go to RESP.
- RESP:
  - rsp_valid is high this cycle.
  - At the edge: rsp_valid <= 0; ptr <= (winner+1) mod N_REQ; go to IDLE.
- Latency: req seen in IDLE at edge t -> gnt high in cycle t..t+1 -> rsp_valid high in cycle t+1..t+2. Throughput is one transaction per 3 cycles.
- Simultaneous requests: exactly one is served per transaction; the others wait with req held.
  - Any requester continuously requesting is served within N_REQ transactions (no starvation).
- req still high in RESP (requester protocol violation): re-arbitrated in the next IDLE. This is legal but counts as a second transaction.
- Operands changing on a_bus/b_bus after capture have no effect on the result.
- rst asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - An in-flight rsp_valid is suppressed; no partial response.
- disp_bin and led hold their value between transactions and change only at the GRANT->RESP edge.
- Comparison is unsigned W-bit; rsp_gt and rsp_eq are never both 1.

Optional Feature:
- Macro CMP_SIGNED_EN.
- Defined: operands are compared as two's complement (W=4 gives range -8..7), and led shows the raw bits.
- Undefined: unsigned comparison.
- All timing and handshake behaviour is identical in both cases.

Decomposition:
- Package cmp_arb_pkg:
  - State enum (IDLE, GRANT, RESP).
  - Localparam ID_W = clog2(N_REQ).
  - Display constants DISP_LE = 4'd0 and DISP_GT = 4'd1.
- Sub-module cmp_core: combinational W-bit comparator producing gt and eq; honours CMP_SIGNED_EN.
- The round-robin priority search stays inline in cmp_share_arb.

Test Plan:
- Reset, then idle: rst high for 2 cycles with req=0 -> all outputs 0, busy=0, no gnt for 10 cycles.
- Single request: req=4'b0001, A0=5, B0=9 -> gnt=0001 one cycle later; next cycle rsp_valid=1, rsp_id=0, rsp_gt=0, rsp_eq=0, disp_bin=0, led=8'h59.
- Round-robin fairness: req=4'b1111 held by a model that drops each req at its gnt, re-raising immediately -> service order 0,1,2,3,0,… with rsp_valid spaced exactly 3 cycles apart.
- Equality and greater: A2=7, B2=7 -> rsp_eq=1, rsp_gt=0, disp_bin=0. Then A3=15, B3=0 -> rsp_gt=1, disp_bin=1, led=8'hF0.
- Reset mid-transaction: rst pulsed during GRANT -> no rsp_valid; ptr=0; next request from id 2 is served normally.
- Signed mode (CMP_SIGNED_EN defined): A=4'b1000 (-8), B=4'b0001 -> rsp_gt=0, disp_bin=0. Same stimulus without the macro -> rsp_gt=1.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the time-shared comparator arbiter.
// State encoding, id width helper and 7-segment display codes.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RESP
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W = $clog2(N_REQ_DEF);

  localparam logic [3:0] DISP_LE = 4'd0;
  localparam logic [3:0] DISP_GT = 4'd1;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_share_arb_cmp_core.sv
// Combinational W-bit magnitude comparator (gt, eq).
// Ports: a, b operands; gt = a > b; eq = a == b. CMP_SIGNED_EN: two's complement.
module cmp_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq
);

`ifdef CMP_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
`else
  assign gt = a > b;
`endif

  assign eq = (a == b);

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one comparator among N_REQ requesters.
// Ports: clk, rst (sync, active-high), req, a_bus, b_bus -> gnt, busy,
// rsp_valid/rsp_id/rsp_gt/rsp_eq, disp_bin, led. Macro: CMP_SIGNED_EN.
module cmp_share_arb
  import cmp_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  localparam int IDW  = id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_bus,
  input  logic [N_REQ*W-1:0] b_bus,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_gt,
  output logic               rsp_eq,
  output logic [3:0]         disp_bin,
  output logic [2*W-1:0]     led
);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   wid;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;

  logic             found;
  logic [IDW-1:0]   win;
  logic [N_REQ-1:0] win_oh;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             gt;
  logic             eq;

  // First set request at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] j;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      j = sum[IDW-1:0];
      if (!found && req[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == IDW'(k)) begin
        win_oh[k] = 1'b1;
        sel_a     = a_bus[k*W +: W];
        sel_b     = b_bus[k*W +: W];
      end
    end
  end

  cmp_core #(
    .W(W)
  ) u_cmp (
    .a  (opa),
    .b  (opb),
    .gt (gt),
    .eq (eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      wid       <= '0;
      opa       <= '0;
      opb       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      disp_bin  <= DISP_LE;
      led       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            opa   <= sel_a;
            opb   <= sel_b;
            wid   <= win;
            gnt   <= win_oh;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt       <= '0;
          rsp_gt    <= gt;
          rsp_eq    <= eq;
          rsp_id    <= wid;
          rsp_valid <= 1'b1;
          disp_bin  <= gt ? DISP_GT : DISP_LE;
          led       <= {opa, opb};
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          ptr       <= (wid == IDW'(N_REQ-1)) ? '0 : wid + 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arb.sv
// Scoreboard bench for cmp_share_arb: directed vectors, queued expectations.
// Monitor pops on rsp_valid; main process checks grants and reset values.
module tb_cmp_share_arb;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus;
  logic [N*W-1:0] b_bus;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic           rsp_gt;
  logic           rsp_eq;
  logic [3:0]     disp_bin;
  logic [2*W-1:0] led;

  cmp_share_arb #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .disp_bin  (disp_bin),
    .led       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    bit         gt;
    bit         eq;
    logic [3:0] disp;
    logic [7:0] led;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_rsp = -1;
  bit   spacing_chk = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got id %0d expected none", rsp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_gt", rsp_gt, e.gt);
        chk("rsp_eq", rsp_eq, e.eq);
        chk("disp_bin", disp_bin, e.disp);
        chk("led", led, e.led);
      end
      if (spacing_chk && last_rsp >= 0) begin
        chk("rsp_spacing", cyc - last_rsp, 3);
      end
      last_rsp = cyc;
    end
  end

  task automatic push(input int id, input bit gt, input bit eq,
                      input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.id   = id;
    e.gt   = gt;
    e.eq   = eq;
    e.disp = gt ? 4'd1 : 4'd0;
    e.led  = {a, b};
    sb.push_back(e);
    gq.push_back(id);
  endtask

  task automatic set_ops(input int i, input logic [3:0] a,
                         input logic [3:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  // Raise mask; each requester drops req when it sees its grant and,
  // with rearm set, raises it again one cycle later.
  task automatic serve(input logic [N-1:0] mask, input int n,
                       input bit rearm);
    int got;
    int budget;
    int e;
    logic [N-1:0] pend;
    got    = 0;
    budget = 0;
    pend   = '0;
    req    = req | mask;
    while (got < n && budget < 80) begin
      @(posedge clk);
      #1;
      budget++;
      req  = req | pend;
      pend = '0;
      if (gnt != '0) begin
        e = (gq.size() > 0) ? gq.pop_front() : -1;
        chk("gnt", gnt, (e >= 0) ? (32'd1 << e) : 32'd0);
        chk("busy_in_grant", busy, 1'b1);
        got++;
        req = req & ~gnt;
        if (rearm && got < n) pend = gnt;
      end
    end
    if (got < n) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: got %0d grants expected %0d", got, n);
    end
    req = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_gt"}, rsp_gt, 0);
    chk({tag, "_rsp_eq"}, rsp_eq, 0);
    chk({tag, "_disp_bin"}, disp_bin, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    rst   = 1'b1;

    // Reset and idle
    do_reset(2);
    chk_reset_outputs("reset");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
    end

    // Single request; operands change after capture
    set_ops(0, 4'd5, 4'd9);
    push(0, 1'b0, 1'b0, 4'd5, 4'd9);
    serve(4'b0001, 1, 1'b0);
    set_ops(0, 4'd15, 4'd0);
    wait_cycles(3);
    chk("idle_after_single", busy, 0);
    chk("disp_hold", disp_bin, 0);
    chk("led_hold", led, 8'h59);

    // Round-robin fairness from ptr=0, rsp every 3 cycles
    do_reset(1);
    set_ops(0, 4'd2, 4'd6);
    set_ops(1, 4'd9, 4'd3);
    set_ops(2, 4'd7, 4'd7);
    set_ops(3, 4'd15, 4'd0);
    for (int r = 0; r < 2; r++) begin
      push(0, 1'b0, 1'b0, 4'd2, 4'd6);
      push(1, 1'b1, 1'b0, 4'd9, 4'd3);
      push(2, 1'b0, 1'b1, 4'd7, 4'd7);
      push(3, 1'b1, 1'b0, 4'd15, 4'd0);
    end
    last_rsp    = -1;
    spacing_chk = 1'b1;
    serve(4'b1111, 8, 1'b1);
    wait_cycles(4);
    spacing_chk = 1'b0;

    // Move ptr to 2, then reset during id 2's GRANT
    set_ops(1, 4'd12, 4'd4);
    push(1, 1'b1, 1'b0, 4'd12, 4'd4);
    serve(4'b0010, 1, 1'b0);
    wait_cycles(3);
    chk("pre_reset_led", led, 8'hC4);
    set_ops(2, 4'd1, 4'd2);
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("mid_gnt", gnt, 4'b0100);
    req = '0;
    do_reset(1);
    chk_reset_outputs("mid_reset");
    wait_cycles(4);
    chk("no_partial_rsp", rsp_valid, 0);

    // ptr back to 0: id 1 wins before id 2
    set_ops(1, 4'd3, 4'd5);
    set_ops(2, 4'd6, 4'd2);
    push(1, 1'b0, 1'b0, 4'd3, 4'd5);
    push(2, 1'b1, 1'b0, 4'd6, 4'd2);
    serve(4'b0110, 2, 1'b0);
    wait_cycles(4);

    // -8 vs 1
    set_ops(0, 4'b1000, 4'b0001);
`ifdef CMP_SIGNED_EN
    push(0, 1'b0, 1'b0, 4'b1000, 4'b0001);
`else
    push(0, 1'b1, 1'b0, 4'b1000, 4'b0001);
`endif
    serve(4'b0001, 1, 1'b0);
    wait_cycles(5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
